// File: rtl/id_regread_stage.sv
// -----------------------------------------------------------------------------
// id_regread_stage
// Decode / register-read stage in front of the ALU. Accepts one RV32I
// instruction per valid/ready handshake, splits it into its fields, reads the
// two source operands from an internal register file (x0 hardwired to zero)
// and holds the result in a one-entry output register for the ALU.
// A writeback port updates the register file. A write that targets a source
// register in the same cycle as a transfer is forwarded into the bundle.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   instr, instr_valid        incoming instruction and its valid
//   instr_ready               stage can take an instruction this cycle
//   wb_en, wb_addr, wb_data   register-file write port
//   RS1, RS2                  captured source operands
//   Funct3, Funct7, opcode    raw instruction fields
//   Imm_reg, Shamt, rd_addr   raw instruction fields (no sign extension)
//   illegal                   opcode is neither OP (0110011) nor OP-IMM (0010011)
//   out_valid, out_ready      output bundle handshake
// -----------------------------------------------------------------------------
module id_regread_stage #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] RS1,
    output logic [WIDTH-1:0] RS2,
    output logic [2:0]       Funct3,
    output logic [6:0]       Funct7,
    output logic [6:0]       opcode,
    output logic [11:0]      Imm_reg,
    output logic [4:0]       Shamt,
    output logic [4:0]       rd_addr,
    output logic             illegal,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Only register-register and register-immediate ALU ops are legal here.
    function automatic logic opcode_illegal(input logic [6:0] op);
        return !((op == 7'b0110011) || (op == 7'b0010011));
    endfunction

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] rf_q [NREGS];

    logic [WIDTH-1:0] rs1_q;
    logic [WIDTH-1:0] rs2_q;
    logic [2:0]       funct3_q;
    logic [6:0]       funct7_q;
    logic [6:0]       opcode_q;
    logic [11:0]      imm_q;
    logic [4:0]       shamt_q;
    logic [4:0]       rd_q;
    logic             illegal_q;

    logic             xfer_s;
    logic             wb_live_s;
    logic [4:0]       rs1_idx_s;
    logic [4:0]       rs2_idx_s;
    logic [WIDTH-1:0] rs1_val_s;
    logic [WIDTH-1:0] rs2_val_s;

    assign rs1_idx_s   = instr[19:15];
    assign rs2_idx_s   = instr[24:20];
    assign out_valid   = (state_q == ST_FULL);
    // Held low during reset so nothing is accepted while state is being cleared.
    assign instr_ready = !rst && (!out_valid || out_ready);
    assign xfer_s      = instr_valid && instr_ready;
    assign wb_live_s   = wb_en && (wb_addr != 5'd0);

    // Operand read with x0 forced to zero and same-cycle writeback forwarding.
    always_comb begin
        rs1_val_s = '0;
        rs2_val_s = '0;
        if (rs1_idx_s == 5'd0) begin
            rs1_val_s = '0;
        end else if (wb_live_s && (wb_addr == rs1_idx_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = rf_q[rs1_idx_s];
        end
        if (rs2_idx_s == 5'd0) begin
            rs2_val_s = '0;
        end else if (wb_live_s && (wb_addr == rs2_idx_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = rf_q[rs2_idx_s];
        end
    end

    // Register file: cleared on reset, writes to x0 dropped so entry 0 stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_live_s) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Output-register occupancy next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (xfer_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer_s) begin
                    state_d = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output bundle: loads only on transfer, otherwise held for the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct3_q  <= 3'd0;
            funct7_q  <= 7'd0;
            opcode_q  <= 7'd0;
            imm_q     <= 12'd0;
            shamt_q   <= 5'd0;
            rd_q      <= 5'd0;
            illegal_q <= 1'b0;
        end else if (xfer_s) begin
            rs1_q     <= rs1_val_s;
            rs2_q     <= rs2_val_s;
            funct3_q  <= instr[14:12];
            funct7_q  <= instr[31:25];
            opcode_q  <= instr[6:0];
            imm_q     <= instr[31:20];
            shamt_q   <= instr[24:20];
            rd_q      <= instr[11:7];
            illegal_q <= opcode_illegal(instr[6:0]);
        end
    end

    assign RS1     = rs1_q;
    assign RS2     = rs2_q;
    assign Funct3  = funct3_q;
    assign Funct7  = funct7_q;
    assign opcode  = opcode_q;
    assign Imm_reg = imm_q;
    assign Shamt   = shamt_q;
    assign rd_addr = rd_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_id_regread_stage.sv
module tb_id_regread_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] RS1;
    logic [31:0] RS2;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [6:0]  opcode;
    logic [11:0] Imm_reg;
    logic [4:0]  Shamt;
    logic [4:0]  rd_addr;
    logic        illegal;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    id_regread_stage #(.WIDTH(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .RS1(RS1), .RS2(RS2), .Funct3(Funct3), .Funct7(Funct7),
        .opcode(opcode), .Imm_reg(Imm_reg), .Shamt(Shamt), .rd_addr(rd_addr),
        .illegal(illegal), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return m_rf[idx];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
            m_valid <= 1'b0;
            m_instr <= 32'd0;
            m_rs1   <= 32'd0;
            m_rs2   <= 32'd0;
        end else begin
            if (instr_valid && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                m_instr <= instr;
                m_rs1   <= m_read(instr[19:15]);
                m_rs2   <= m_read(instr[24:20]);
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] <= wb_data;
        end
    end

    // Per-cycle comparison against the model (inputs change 1 time unit after negedge).
    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("instr_ready", {31'd0, instr_ready}, {31'd0, (!rst && (!m_valid || out_ready))});
        if (m_valid) begin
            chk("RS1", RS1, m_rs1);
            chk("RS2", RS2, m_rs2);
            chk("Funct3", {29'd0, Funct3}, {29'd0, m_instr[14:12]});
            chk("Funct7", {25'd0, Funct7}, {25'd0, m_instr[31:25]});
            chk("opcode", {25'd0, opcode}, {25'd0, m_instr[6:0]});
            chk("Imm_reg", {20'd0, Imm_reg}, {20'd0, m_instr[31:20]});
            chk("Shamt", {27'd0, Shamt}, {27'd0, m_instr[24:20]});
            chk("rd_addr", {27'd0, rd_addr}, {27'd0, m_instr[11:7]});
            chk("illegal", {31'd0, illegal},
                {31'd0, !(m_instr[6:0] == 7'h33 || m_instr[6:0] == 7'h13)});
        end
    end

    // One clock: the edge happens, then wait past the negedge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr = 32'd0; instr_valid = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        cyc(); cyc();
        chk("lit_reset_valid", {31'd0, out_valid}, 32'd0);
        chk("lit_reset_RS1", RS1, 32'd0);
        rst = 1'b0;
        #1;
        chk("lit_ready_empty", {31'd0, instr_ready}, 32'd1);

        // x1 = 5, x2 = 3
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5; cyc();
        wb_addr = 5'd2; wb_data = 32'd3; cyc();
        wb_en = 1'b0;

        // ADD x3,x1,x2
        instr = 32'h002081B3; instr_valid = 1'b1; cyc();
        chk("lit_add_valid", {31'd0, out_valid}, 32'd1);
        chk("lit_add_RS1", RS1, 32'd5);
        chk("lit_add_RS2", RS2, 32'd3);
        chk("lit_add_opcode", {25'd0, opcode}, 32'h33);
        chk("lit_add_rd", {27'd0, rd_addr}, 32'd3);
        chk("lit_add_illegal", {31'd0, illegal}, 32'd0);
        instr_valid = 1'b0; cyc();

        // SUB x3,x1,x2 held with out_ready=0; ADDI waits behind it
        out_ready = 1'b0; instr = 32'h402081B3; instr_valid = 1'b1; cyc();
        instr = 32'h00500093;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h77;  // write while FULL
        for (int i = 0; i < 3; i++) begin
            cyc();
            wb_en = 1'b0;
            chk("lit_stall_funct7", {25'd0, Funct7}, 32'h20);
            chk("lit_stall_RS2", RS2, 32'd3);
            chk("lit_stall_ready", {31'd0, instr_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("lit_ready_release", {31'd0, instr_ready}, 32'd1);
        cyc();
        chk("lit_addi_RS1", RS1, 32'd0);
        chk("lit_addi_imm", {20'd0, Imm_reg}, 32'h005);
        chk("lit_addi_shamt", {27'd0, Shamt}, 32'd5);
        chk("lit_addi_opcode", {25'd0, opcode}, 32'h13);
        chk("lit_addi_rd", {27'd0, rd_addr}, 32'd1);

        // Bypass: ADD x3,x1,x2 with same-cycle write x1
        instr = 32'h002081B3; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEADBEEF; cyc();
        chk("lit_bypass_RS1", RS1, 32'hDEADBEEF);
        chk("lit_bypass_RS2", RS2, 32'h77);
        // Write to x0 alongside a read of x0, then read x0 again
        instr = 32'h000001B3; wb_addr = 5'd0; wb_data = 32'h12345678; cyc();
        chk("lit_x0_same", RS1, 32'd0);
        wb_en = 1'b0; cyc();
        chk("lit_x0_later", RS1, 32'd0);

        // Four back-to-back ADDs with rd = 4..7
        for (int i = 0; i < 4; i++) begin
            instr = 32'h00208033 | (32'(4 + i) << 7);
            cyc();
            chk("lit_b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("lit_b2b_rd", {27'd0, rd_addr}, 32'(4 + i));
            chk("lit_b2b_RS1", RS1, 32'hDEADBEEF);
        end
        instr_valid = 1'b0; cyc();
        chk("lit_drain_valid", {31'd0, out_valid}, 32'd0);

        // Reset while FULL clears immediately
        instr = 32'h002081B3; instr_valid = 1'b1; cyc();
        instr_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("lit_arst_valid", {31'd0, out_valid}, 32'd0);
        chk("lit_arst_RS1", RS1, 32'd0);
        chk("lit_arst_opcode", {25'd0, opcode}, 32'd0);
        chk("lit_arst_rd", {27'd0, rd_addr}, 32'd0);
        cyc();
        rst = 1'b0; out_ready = 1'b1;
        // LW x5,0(x1): illegal opcode, x1 cleared by reset
        instr = 32'h0000A283; instr_valid = 1'b1; cyc();
        chk("lit_lw_illegal", {31'd0, illegal}, 32'd1);
        chk("lit_lw_RS1", RS1, 32'd0);
        chk("lit_lw_funct3", {29'd0, Funct3}, 32'd2);
        instr_valid = 1'b0; cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_regread_stage.md
Name: id_regread_stage

Overview:
- Decode and register-read stage sitting directly upstream of the ALU.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and splits them into fields.
- Reads two operands from an internal 32x32 register file and presents registered RS1/RS2/Funct3/Funct7/opcode/Imm_reg/Shamt to the ALU with a valid/ready output handshake.
- Accepts the writeback port that returns ALU results to the register file.

Parameters:
- WIDTH, 32, data width of register file entries and operands.
- NREGS, 32, number of architectural registers; entry 0 is hardwired to zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  32  instruction word.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  stage can accept instr this cycle.
- wb_en  input  1  register-file write enable.
- wb_addr  input  5  write register index.
- wb_data  input  WIDTH  write data.
- RS1  output  WIDTH  operand from rs1 field.
- RS2  output  WIDTH  operand from rs2 field.
- Funct3  output  3  instr[14:12].
- Funct7  output  7  instr[31:25].
- opcode  output  7  instr[6:0].
- Imm_reg  output  12  instr[31:20].
- Shamt  output  5  instr[24:20].
- rd_addr  output  5  instr[11:7], destination index for writeback.
- illegal  output  1  opcode is neither 0110011 nor 0010011.
- out_valid  output  1  output bundle valid.
- out_ready  input  1  ALU side consumes bundle.

Behaviour:
- Reset (async, rst=1):
  - All register-file entries become 0.
  - out_valid=0.
  - RS1, RS2, Funct3, Funct7, opcode, Imm_reg, Shamt, rd_addr and illegal become 0.
  - instr_ready is 1 while rst is low and the output register is empty.
  - Reset mid-operation drops any held bundle and ignores any pending write.
- Handshake:
  - instr_ready = !out_valid || out_ready (combinational).
  - Transfer occurs when instr_valid && instr_ready.
  - On transfer, all output fields load on the same edge and out_valid=1 next cycle.
  - Latency is 1 cycle from accepted instr to out_valid.
- Out_valid update:
  - Clears when out_valid && out_ready with no new transfer.
  - Stays 1 on back-to-back transfers.
  - Outputs hold stable while out_valid && !out_ready.
- Two-state view: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on transfer.
  - FULL -> FULL on transfer with out_ready.
  - FULL -> EMPTY on out_ready without transfer.
  - FULL holds otherwise.
- Register file:
  - Written on rising edge when wb_en=1 and wb_addr!=0.
  - Writes to x0 are discarded; reads of x0 return 0.
  - Write-through bypass: if wb_en=1, wb_addr!=0 and wb_addr equals instr[19:15] (or instr[24:20]) in the transfer cycle, the captured RS1 (or RS2) is wb_data, not the stale entry.
  - Writeback is independent of handshake state; a write while FULL updates only the file, never the held bundle.
- Field rules:
  - Imm_reg and Shamt are raw slices, not sign-extended; RS2 is still read for I-type.
  - illegal is registered with the bundle; the bundle is still forwarded.
- Simultaneous events: a transfer and a writeback to the same index in one cycle use the bypassed value; both take effect on the same edge.

Test Plan:
- Reset then write x1=5, x2=3; send 0x002081B3 (ADD x3,x1,x2) -> next cycle out_valid=1, RS1=5, RS2=3, opcode=0x33, Funct3=0, Funct7=0, rd_addr=3, illegal=0.
- Send 0x402081B3 with out_ready=0 for 3 cycles -> Funct7=0x20, outputs stable, instr_ready=0; raise out_ready -> instr_ready=1 the same cycle.
- Send 0x00500093 (ADDI x1,x0,5) -> RS1=0, Imm_reg=0x005, Shamt=5, opcode=0x13, rd_addr=1.
- wb_en=1, wb_addr=1, wb_data=0xDEADBEEF in the same cycle as ADD x3,x1,x2 transfer -> RS1=0xDEADBEEF (bypass); write to x0 -> later read of x0 returns 0.
- Back-to-back 4 instructions with out_ready=1 -> out_valid stays high 4 cycles, one bundle per cycle, in order.
- Assert rst while FULL -> out_valid=0 and all outputs 0 immediately (before the next clock edge); x1 reads 0 afterwards; opcode 0x03 -> illegal=1.
